// File: rtl/inst_encode.sv
// inst_encode: RV32I instruction encoder, the inverse of the decode stage.
// Packs split fields into a 32-bit word through a two-stage valid/ready
// pipeline: stage A registers the fields and the format, stage B registers
// the packed word and drives the outputs.
// Optional build macro INST_ENCODE_RANGE_CHECK_EN: also flag immediates
// that the chosen format cannot represent exactly.
module inst_encode #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count
);

    // One-hot format bit positions
    localparam int F_R   = 0;
    localparam int F_I   = 1;
    localparam int F_S   = 2;
    localparam int F_B   = 3;
    localparam int F_U   = 4;
    localparam int F_J   = 5;
    localparam int F_Z   = 6;
    localparam int F_NA  = 7;
    localparam int F_BAD = 8;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] imm;
        logic [8:0]  fmt;
    } req_t;

    // vld_pipe[0]: input handshake, [1]: stage A valid, [2]: stage B valid
    logic [2:0]  vld_pipe;
    logic        b_adv;
    logic [8:0]  fmt_d;
    req_t        a_q;
    logic [31:0] inst_d;
    logic        range_err;
    logic        err_d;

    assign b_adv       = !vld_pipe[2] || out_ready;
    assign in_ready    = !vld_pipe[1] || b_adv;
    assign vld_pipe[0] = in_valid && in_ready;
    assign out_valid   = vld_pipe[2];

    // Major opcode to one-hot format, same map as decode
    always_comb begin
        fmt_d = '0;
        case (opcode)
            5'b01100:                   fmt_d[F_R]   = 1'b1;
            5'b00000, 5'b00100,
            5'b11001:                   fmt_d[F_I]   = 1'b1;
            5'b01000:                   fmt_d[F_S]   = 1'b1;
            5'b11000:                   fmt_d[F_B]   = 1'b1;
            5'b01101, 5'b00101:         fmt_d[F_U]   = 1'b1;
            5'b11011:                   fmt_d[F_J]   = 1'b1;
            5'b11100:                   fmt_d[F_Z]   = 1'b1;
            5'b00011:                   fmt_d[F_NA]  = 1'b1;
            default:                    fmt_d[F_BAD] = 1'b1;
        endcase
    end

    // Stage A: capture the field bundle whenever A is free or draining into B
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[1] <= 1'b0;
            a_q         <= '0;
        end else if (in_ready) begin
            vld_pipe[1] <= in_valid;
            if (in_valid)
                a_q <= '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2, func3: func3,
                         func7: func7, imm: imm, fmt: fmt_d};
        end
    end

    // Pack stage-A fields into the instruction word for its format
    always_comb begin
        inst_d = {a_q.func7, a_q.rs2, a_q.rs1, a_q.func3, a_q.rd, a_q.opcode, 2'b11};
        unique case (1'b1)
            a_q.fmt[F_I], a_q.fmt[F_NA]:
                inst_d = {a_q.imm[11:0], a_q.rs1, a_q.func3, a_q.rd, a_q.opcode, 2'b11};
            a_q.fmt[F_S]:
                inst_d = {a_q.imm[11:5], a_q.rs2, a_q.rs1, a_q.func3, a_q.imm[4:0],
                          a_q.opcode, 2'b11};
            a_q.fmt[F_B]:
                inst_d = {a_q.imm[12], a_q.imm[10:5], a_q.rs2, a_q.rs1, a_q.func3,
                          a_q.imm[4:1], a_q.imm[11], a_q.opcode, 2'b11};
            a_q.fmt[F_U]:
                inst_d = {a_q.imm[31:12], a_q.rd, a_q.opcode, 2'b11};
            a_q.fmt[F_J]:
                inst_d = {a_q.imm[20], a_q.imm[10:1], a_q.imm[11], a_q.imm[19:12],
                          a_q.rd, a_q.opcode, 2'b11};
            a_q.fmt[F_Z]:
                // imm zero-extends into the rs1 slot (decode's immZ)
                inst_d = {a_q.func7, a_q.rs2, a_q.imm[4:0], a_q.func3, a_q.rd,
                          a_q.opcode, 2'b11};
            default: ;  // R and BAD keep the R layout
        endcase
    end

`ifdef INST_ENCODE_RANGE_CHECK_EN
    // Flag immediates that the format would silently truncate
    always_comb begin
        range_err = 1'b0;
        unique case (1'b1)
            a_q.fmt[F_I], a_q.fmt[F_NA], a_q.fmt[F_S]:
                range_err = !((&a_q.imm[31:11]) || !(|a_q.imm[31:11]));
            a_q.fmt[F_B]:
                range_err = !((&a_q.imm[31:12]) || !(|a_q.imm[31:12])) || a_q.imm[0];
            a_q.fmt[F_J]:
                range_err = !((&a_q.imm[31:20]) || !(|a_q.imm[31:20])) || a_q.imm[0];
            a_q.fmt[F_U]:
                range_err = |a_q.imm[11:0];
            a_q.fmt[F_Z]:
                range_err = |a_q.imm[31:5];
            default: ;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    assign err_d = a_q.fmt[F_BAD] || range_err;

    // Stage B: load the packed word when empty or when the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[2] <= 1'b0;
            out_inst    <= '0;
            out_err     <= 1'b0;
        end else if (b_adv) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                out_inst <= inst_d;
                out_err  <= err_d;
            end
        end
    end

    // Count accepted bundles, wrapping at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            enc_count <= '0;
        else if (vld_pipe[0])
            enc_count <= enc_count + CNT_W'(1);
    end

endmodule
